// File: rtl/memory_stage_pipe.sv
// memory_stage_pipe: EX->MEM stage with forwarding, ALU and
// valid/ready flow control through a two-entry skid buffer.
package memory_stage_pkg;
   typedef enum logic [3:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_XOR,
      ALU_SLT,
      ALU_SLTU,
      ALU_SLL,
      ALU_SRL,
      ALU_SRA
   } alu_op_t;
endpackage

module alu
   import memory_stage_pkg::*;
#(
   parameter int DPW = 32
) (
   input  logic [DPW-1:0] a,
   input  logic [DPW-1:0] b,
   input  alu_op_t        op,
   output logic [DPW-1:0] y
);
   localparam int SW = $clog2(DPW);

   logic [SW-1:0] sh;
   assign sh = b[SW-1:0];

   // operation decode
   always_comb begin
      y = '0;
      unique case (op)
         ALU_ADD:  y = a + b;
         ALU_SUB:  y = a - b;
         ALU_AND:  y = a & b;
         ALU_OR:   y = a | b;
         ALU_XOR:  y = a ^ b;
         ALU_SLT:  y = {{(DPW-1){1'b0}}, $signed(a) < $signed(b)};
         ALU_SLTU: y = {{(DPW-1){1'b0}}, a < b};
         ALU_SLL:  y = a << sh;
         ALU_SRL:  y = a >> sh;
         ALU_SRA:  y = $signed(a) >>> sh;
         default:  y = '0;
      endcase
   end
endmodule

module memory_stage_pipe
   import memory_stage_pkg::*;
#(
   parameter int DPW = 32,
   parameter int RAW = 5
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           valid_i,
   output logic           ready_o,
   input  logic           flush_i,
   input  logic           regwriteE,
   input  logic           resultsrcE,
   input  logic           memwriteE,
   input  alu_op_t        alu_ctrlE,
   input  logic           alusrcE,
   input  logic [DPW-1:0] Rd1E,
   input  logic [DPW-1:0] Rd2E,
   input  logic [DPW-1:0] immextE,
   input  logic [RAW-1:0] RdE,
   input  logic [1:0]     fwdAE,
   input  logic [1:0]     fwdBE,
   input  logic [DPW-1:0] resultW,
   output logic           valid_o,
   input  logic           ready_i,
   output logic           regwriteM,
   output logic           resultsrcM,
   output logic           memwriteM,
   output logic [DPW-1:0] aluresultM,
   output logic [DPW-1:0] Rd2M,
   output logic [RAW-1:0] RdM,
   output logic [DPW-1:0] srcB
);
   typedef struct packed {
      logic           regwrite;
      logic           resultsrc;
      logic           memwrite;
      logic [DPW-1:0] alures;
      logic [DPW-1:0] rd2;
      logic [RAW-1:0] rd;
   } beat_t;

   logic [DPW-1:0] srcA;
   logic [DPW-1:0] fwdB;
   logic [DPW-1:0] aluresultE;
   beat_t          beat;
   beat_t          or_q;
   beat_t          sr_q;
   logic           or_v;
   logic           sr_v;
   logic           acc;
   logic           xfer;
   logic           ld_or_new;
   logic           ld_or_skid;
   logic           ld_sr;

   // forwarding muxes; code 11 falls back to the register file
   always_comb begin
      srcA = Rd1E;
      fwdB = Rd2E;
      unique case (1'b1)
         (fwdAE == 2'b01): srcA = or_q.alures;
         (fwdAE == 2'b10): srcA = resultW;
         default:          srcA = Rd1E;
      endcase
      unique case (1'b1)
         (fwdBE == 2'b01): fwdB = or_q.alures;
         (fwdBE == 2'b10): fwdB = resultW;
         default:          fwdB = Rd2E;
      endcase
   end

   assign srcB = alusrcE ? immextE : fwdB;

   alu #(.DPW(DPW)) u_alu (
      .a  (srcA),
      .b  (srcB),
      .op (alu_ctrlE),
      .y  (aluresultE)
   );

   assign beat = '{
      regwrite:  regwriteE,
      resultsrc: resultsrcE,
      memwrite:  memwriteE,
      alures:    aluresultE,
      rd2:       fwdB,
      rd:        RdE
   };

   assign ready_o    = ~sr_v;
   assign acc        = valid_i & ready_o;
   assign xfer       = or_v & ready_i;
   assign ld_or_skid = ~flush_i & xfer & sr_v;
   assign ld_or_new  = ~flush_i & acc & (~or_v | xfer);
   assign ld_sr      = ~flush_i & acc & or_v & ~xfer;

   // occupancy of output and skid entries
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         or_v <= 1'b0;
         sr_v <= 1'b0;
      end else if (flush_i) begin
         or_v <= 1'b0;
         sr_v <= 1'b0;
      end else if (ld_or_skid) begin
         or_v <= 1'b1;
         sr_v <= 1'b0;
      end else if (ld_or_new) begin
         or_v <= 1'b1;
      end else if (ld_sr) begin
         sr_v <= 1'b1;
      end else if (xfer) begin
         or_v <= 1'b0;
      end
   end

   // output entry payload, loaded only on accept or skid move
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         or_q <= '0;
      end else if (ld_or_skid) begin
         or_q <= sr_q;
      end else if (ld_or_new) begin
         or_q <= beat;
      end
   end

   // skid entry payload, loaded only on overflow accept
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr_q <= '0;
      end else if (ld_sr) begin
         sr_q <= beat;
      end
   end

   assign valid_o    = or_v;
   assign regwriteM  = or_v & or_q.regwrite;
   assign memwriteM  = or_v & or_q.memwrite;
   assign resultsrcM = or_q.resultsrc;
   assign aluresultM = or_q.alures;
   assign Rd2M       = or_q.rd2;
   assign RdM        = or_q.rd;
endmodule

// File: tb/tb_memory_stage_pipe.sv
// tb_memory_stage_pipe: directed vector table plus hand-written
// backpressure, flush and reset sequences.
module tb_memory_stage_pipe;
   import memory_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_i, ready_o, flush_i;
   logic        regwriteE, resultsrcE, memwriteE;
   alu_op_t     alu_ctrlE;
   logic        alusrcE;
   logic [31:0] Rd1E, Rd2E, immextE, resultW;
   logic [4:0]  RdE;
   logic [1:0]  fwdAE, fwdBE;
   logic        valid_o, ready_i;
   logic        regwriteM, resultsrcM, memwriteM;
   logic [31:0] aluresultM, Rd2M, srcB;
   logic [4:0]  RdM;

   int n_vec = 0;
   int n_bad = 0;

   memory_stage_pipe #(.DPW(32), .RAW(5)) dut (
      .clk        (clk),
      .rst        (rst),
      .valid_i    (valid_i),
      .ready_o    (ready_o),
      .flush_i    (flush_i),
      .regwriteE  (regwriteE),
      .resultsrcE (resultsrcE),
      .memwriteE  (memwriteE),
      .alu_ctrlE  (alu_ctrlE),
      .alusrcE    (alusrcE),
      .Rd1E       (Rd1E),
      .Rd2E       (Rd2E),
      .immextE    (immextE),
      .RdE        (RdE),
      .fwdAE      (fwdAE),
      .fwdBE      (fwdBE),
      .resultW    (resultW),
      .valid_o    (valid_o),
      .ready_i    (ready_i),
      .regwriteM  (regwriteM),
      .resultsrcM (resultsrcM),
      .memwriteM  (memwriteM),
      .aluresultM (aluresultM),
      .Rd2M       (Rd2M),
      .RdM        (RdM),
      .srcB       (srcB)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        vi;
      alu_op_t     op;
      logic        asrc;
      logic [1:0]  fa;
      logic [1:0]  fb;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [31:0] resw;
      logic [4:0]  rd;
      logic        rw;
      logic        rs;
      logic        mw;
      logic        e_v;
      logic [31:0] e_srcb;
      logic [31:0] e_alu;
      logic [31:0] e_rd2;
      logic [4:0]  e_rd;
      logic        e_rw;
      logic        e_rs;
      logic        e_mw;
   } vec_t;

   vec_t tbl[14];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic idle();
      valid_i    = 1'b0;
      flush_i    = 1'b0;
      regwriteE  = 1'b0;
      resultsrcE = 1'b0;
      memwriteE  = 1'b0;
      alu_ctrlE  = ALU_ADD;
      alusrcE    = 1'b0;
      Rd1E       = '0;
      Rd2E       = '0;
      immextE    = '0;
      RdE        = '0;
      fwdAE      = 2'b00;
      fwdBE      = 2'b00;
      resultW    = '0;
   endtask

   task automatic send(input logic v, input logic [31:0] a,
                       input logic [4:0] r);
      idle();
      valid_i   = v;
      regwriteE = 1'b1;
      Rd1E      = a;
      RdE       = r;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // vi op asrc fa fb rd1 rd2 imm resw rd rw rs mw |
      // e_v e_srcb e_alu e_rd2 e_rd e_rw e_rs e_mw
      tbl[0]  = '{1, ALU_ADD, 0, 0, 0, 5, 7, 0, 0, 3, 1, 0, 0,
                  1, 7, 12, 7, 3, 1, 0, 0};
      tbl[1]  = tbl[0];
      tbl[2]  = tbl[0];
      tbl[3]  = tbl[0];
      tbl[4]  = '{1, ALU_ADD, 1, 1, 2, 99, 1, 32'h10, 32'hAB, 5,
                  0, 0, 1, 1, 32'h10, 32'h1C, 32'hAB, 5, 0, 0, 1};
      tbl[5]  = '{1, ALU_SUB, 0, 0, 0, 32'h20, 8, 0, 0, 7, 1, 1, 0,
                  1, 8, 32'h18, 8, 7, 1, 1, 0};
      tbl[6]  = '{1, ALU_OR, 0, 3, 3, 3, 4, 0, 32'hDEAD, 8, 1, 0, 0,
                  1, 4, 7, 4, 8, 1, 0, 0};
      tbl[7]  = '{1, ALU_XOR, 0, 0, 1, 32'hF, 32'h100, 0, 0, 9,
                  1, 0, 0, 1, 7, 8, 7, 9, 1, 0, 0};
      tbl[8]  = '{1, ALU_SLT, 0, 0, 0, 32'hFFFFFFFF, 1, 0, 0, 10,
                  1, 0, 0, 1, 1, 1, 1, 10, 1, 0, 0};
      tbl[9]  = '{1, ALU_SLTU, 0, 0, 0, 32'hFFFFFFFF, 1, 0, 0, 11,
                  1, 0, 0, 1, 1, 0, 1, 11, 1, 0, 0};
      tbl[10] = '{1, ALU_SLL, 1, 0, 0, 1, 32'h55, 4, 0, 12,
                  1, 0, 1, 1, 4, 16, 32'h55, 12, 1, 0, 1};
      tbl[11] = '{1, ALU_SRA, 0, 0, 0, 32'h80000000, 4, 0, 0, 13,
                  1, 0, 0, 1, 4, 32'hF8000000, 4, 13, 1, 0, 0};
      tbl[12] = '{1, ALU_SRL, 0, 0, 0, 32'h80000000, 4, 0, 0, 14,
                  1, 0, 0, 1, 4, 32'h08000000, 4, 14, 1, 0, 0};
      tbl[13] = '{0, ALU_ADD, 0, 0, 0, 32'h1234, 0, 0, 0, 20,
                  1, 1, 1, 0, 0, 32'h08000000, 4, 14, 0, 0, 0};

      idle();
      ready_i = 1'b0;
      rst = 1'b1;
      #1;
      chk("rst_valid_o", 32'(valid_o), 0);
      chk("rst_ready_o", 32'(ready_o), 1);
      chk("rst_alu", aluresultM, 0);
      chk("rst_rw", 32'(regwriteM), 0);
      @(negedge clk);
      rst = 1'b0;
      tick();

      ready_i = 1'b1;
      for (int i = 0; i < 14; i++) begin
         idle();
         valid_i    = tbl[i].vi;
         alu_ctrlE  = tbl[i].op;
         alusrcE    = tbl[i].asrc;
         fwdAE      = tbl[i].fa;
         fwdBE      = tbl[i].fb;
         Rd1E       = tbl[i].rd1;
         Rd2E       = tbl[i].rd2;
         immextE    = tbl[i].imm;
         resultW    = tbl[i].resw;
         RdE        = tbl[i].rd;
         regwriteE  = tbl[i].rw;
         resultsrcE = tbl[i].rs;
         memwriteE  = tbl[i].mw;
         #1;
         chk($sformatf("v%0d_srcB", i), srcB, tbl[i].e_srcb);
         tick();
         chk($sformatf("v%0d_valid", i), 32'(valid_o),
             32'(tbl[i].e_v));
         chk($sformatf("v%0d_alu", i), aluresultM, tbl[i].e_alu);
         chk($sformatf("v%0d_rd2", i), Rd2M, tbl[i].e_rd2);
         chk($sformatf("v%0d_rd", i), 32'(RdM), 32'(tbl[i].e_rd));
         chk($sformatf("v%0d_rw", i), 32'(regwriteM),
             32'(tbl[i].e_rw));
         chk($sformatf("v%0d_rs", i), 32'(resultsrcM),
             32'(tbl[i].e_rs));
         chk($sformatf("v%0d_mw", i), 32'(memwriteM),
             32'(tbl[i].e_mw));
      end

      // backpressure: A in OR, B in skid, C refused until drain
      ready_i = 1'b0;
      send(1, 32'h100, 1);
      tick();
      chk("bp_a_valid", 32'(valid_o), 1);
      chk("bp_a_alu", aluresultM, 32'h100);
      chk("bp_a_ready", 32'(ready_o), 1);
      send(1, 32'h200, 2);
      tick();
      chk("bp_b_ready", 32'(ready_o), 0);
      chk("bp_b_hold", aluresultM, 32'h100);
      send(1, 32'h300, 3);
      tick();
      chk("bp_c_ready", 32'(ready_o), 0);
      chk("bp_c_hold", 32'(RdM), 1);
      tick();
      chk("bp_c_hold2", aluresultM, 32'h100);
      ready_i = 1'b1;
      tick();
      chk("bp_b_out", aluresultM, 32'h200);
      chk("bp_b_rdo", 32'(ready_o), 1);
      chk("bp_b_v", 32'(valid_o), 1);
      tick();
      chk("bp_c_out", aluresultM, 32'h300);
      chk("bp_c_rd", 32'(RdM), 3);
      chk("bp_c_v", 32'(valid_o), 1);
      idle();
      tick();
      chk("bp_drain", 32'(valid_o), 0);

      // flush discards a beat accepted in the same cycle
      send(1, 32'h444, 4);
      flush_i = 1'b1;
      tick();
      chk("fl1_valid", 32'(valid_o), 0);
      chk("fl1_ready", 32'(ready_o), 1);
      idle();

      // flush with both entries full and a third beat offered
      ready_i = 1'b0;
      send(1, 32'h11, 5);
      tick();
      send(1, 32'h22, 6);
      tick();
      chk("fl2_full", 32'(ready_o), 0);
      send(1, 32'h33, 7);
      flush_i = 1'b1;
      tick();
      chk("fl2_valid", 32'(valid_o), 0);
      chk("fl2_ready", 32'(ready_o), 1);
      idle();
      ready_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("fl2_empty%0d", k), 32'(valid_o), 0);
      end

      // asynchronous reset while stalled with both entries full
      ready_i = 1'b0;
      send(1, 32'h55, 9);
      tick();
      send(1, 32'h66, 10);
      tick();
      chk("ar_full", 32'(ready_o), 0);
      chk("ar_v", 32'(valid_o), 1);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_valid_o", 32'(valid_o), 0);
      chk("ar_ready_o", 32'(ready_o), 1);
      chk("ar_alu", aluresultM, 0);
      chk("ar_rd2", Rd2M, 0);
      chk("ar_rd", 32'(RdM), 0);
      chk("ar_rw", 32'(regwriteM), 0);
      chk("ar_mw", 32'(memwriteM), 0);
      chk("ar_rs", 32'(resultsrcM), 0);
      idle();
      @(negedge clk);
      rst = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
